spi_peripheral_responder: RTL and testbench

SPI target (peripheral) that answers the frames issued by the team's SPI controller. It decodes the {WnR, 10-bit address, N×32-bit data} frame and drives a simple register-bus port into a user register bank: writes are emitted as single-cycle strobes, and reads fetch words and shift them out on `poci`. It is used in two places: as the chip-side model in loopback benches against the controller, and as the configuration front end for FPGA-side emulated peripherals.

---
 rtl/spi_peripheral_responder.sv | 179 +++++++++++++++++
 tb/tb_spi_peripheral_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral_responder.sv
// SPI mode-0 target: decodes {WnR, address, N x word} frames into register-bus write strobes and read fetches.
// Define SPI_PERIPHERAL_SYNC_EN to pass spi_clk, cs_b and pico through 2-flop synchronizers first.
module spi_peripheral_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  axi_clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  cs_b,
    input  logic                  pico,
    output logic                  poci,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CMD_BITS = ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2((DATA_WIDTH > CMD_BITS) ? DATA_WIDTH : CMD_BITS);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RDATA = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic sclk_s, cs_s, pico_s;
    logic sclk_q, cs_q;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

`ifdef SPI_PERIPHERAL_SYNC_EN
    logic [1:0] sclk_sync, cs_sync, pico_sync;

    always_ff @(posedge axi_clk) begin
        sclk_sync <= {sclk_sync[0], spi_clk};
        cs_sync   <= {cs_sync[0], cs_b};
        pico_sync <= {pico_sync[0], pico};
    end

    assign sclk_s = sclk_sync[1];
    assign cs_s   = cs_sync[1];
    assign pico_s = pico_sync[1];
`else
    assign sclk_s = spi_clk;
    assign cs_s   = cs_b;
    assign pico_s = pico;
`endif

    // Edge history keeps sampling through reset so the post-reset state sees the true cs_b level.
    always_ff @(posedge axi_clk) begin
        sclk_q <= sclk_s;
        cs_q   <= cs_s;
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

    logic [2:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [ADDR_WIDTH-1:0] cmd_sr;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  load_pending;
    logic                  in_frame;
    logic [ADDR_WIDTH-1:0] cmd_next;
    logic [DATA_WIDTH-1:0] word_next;

    assign in_frame  = (state == ST_CMD) || (state == ST_WDATA) || (state == ST_RDATA);
    assign cmd_next  = {cmd_sr[ADDR_WIDTH-2:0], pico_s};
    assign word_next = {data_sr[DATA_WIDTH-2:0], pico_s};

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state        <= cs_s ? ST_IDLE : ST_DRAIN;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            data_sr      <= '0;
            addr         <= '0;
            load_pending <= 1'b0;
            poci         <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            rd_en        <= 1'b0;
            frame_done   <= 1'b0;
            load_pending <= rd_en;

            // A chip-select release wins over any spi_clk edge seen in the same cycle.
            if (in_frame && cs_rise) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                poci       <= 1'b0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_CMD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr  <= cmd_next;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= '0;
                                addr    <= cmd_next;
                                if (cmd_sr[ADDR_WIDTH-1]) begin
                                    state <= ST_WDATA;
                                end else begin
                                    state   <= ST_RDATA;
                                    rd_en   <= 1'b1;
                                    rd_addr <= cmd_next;
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            data_sr <= word_next;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt <= '0;
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= word_next;
                                addr    <= addr + 1'b1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // The bank answers one cycle after rd_en; that word replaces the drained shifter.
                        if (load_pending) begin
                            data_sr <= rd_data;
                        end else if (sclk_fall) begin
                            poci    <= data_sr[DATA_WIDTH-1];
                            data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt <= '0;
                                addr    <= addr + 1'b1;
                                rd_en   <= 1'b1;
                                rd_addr <= addr + 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (cs_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral_responder.sv
// Randomised scoreboard bench for spi_peripheral_responder: a frame-level model predicts bus writes,
// read requests, shifted-out read words and frame_done pulses; a monitor checks the bus as it happens.
`timescale 1ns/1ps
module tb_spi_peripheral_responder;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          axi_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          spi_clk = 1'b0;
    logic          cs_b    = 1'b1;
    logic          pico    = 1'b0;
    logic          poci, wr_en, rd_en, busy, frame_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;

    int vectors     = 0;
    int miscompares = 0;
    int done_pending = 0;

    logic [AW+DW-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    logic [DW-1:0]    exp_rx_q[$];
    logic [DW-1:0]    w[3];

    always #5 axi_clk = ~axi_clk;

    spi_peripheral_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .axi_clk   (axi_clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .cs_b      (cs_b),
        .pico      (pico),
        .poci      (poci),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    function automatic logic [DW-1:0] bank_word(input int a);
        logic [DW-1:0] v;
        v = DW'(a & 1023);
        return v * 32'h01010101;
    endfunction

    // Register bank stand-in: registered read, data valid the cycle after rd_en.
    always_ff @(posedge axi_clk) begin
        if (rd_en) rd_data <= bank_word(int'(rd_addr));
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge axi_clk) begin
        if (wr_en) begin
            if (exp_wr_q.size() == 0) checkOutput("wr_en spurious", 64'(wr_en), 64'd0);
            else checkOutput("wr_addr/wr_data", 64'({wr_addr, wr_data}), 64'(exp_wr_q.pop_front()));
        end
        if (rd_en) begin
            if (exp_rd_q.size() == 0) checkOutput("rd_en spurious", 64'(rd_en), 64'd0);
            else checkOutput("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
        end
        if (frame_done) begin
            checkOutput("busy at frame_done", 64'(busy), 64'd0);
            if (done_pending > 0) done_pending--;
            else checkOutput("frame_done spurious", 64'(frame_done), 64'd0);
        end
    end

    // cut < 0: whole frame; reset_bit >= 0: pulse reset for 2 cycles before that bit.
    task automatic applyStimulus(input bit wnr, input int addr, input int nwords, input logic [DW-1:0] words[3],
                                 input int half, input int cut, input int reset_bit);
        logic bits[$];
        logic [DW-1:0] rx;
        int rx_cnt, nbits, stop, full;
        bits.push_back(wnr);
        for (int b = AW - 1; b >= 0; b--) bits.push_back(addr[b]);
        for (int k = 0; k < nwords; k++)
            for (int b = DW - 1; b >= 0; b--) bits.push_back(words[k][b]);
        nbits = (cut >= 0) ? cut : bits.size();
        while (bits.size() > nbits) void'(bits.pop_back());

        stop = (reset_bit >= 0) ? reset_bit : nbits;
        full = (stop >= AW + 1) ? (stop - AW - 1) / DW : 0;
        if (stop >= AW + 1) begin
            if (wnr) begin
                for (int k = 0; k < full; k++) exp_wr_q.push_back({AW'(addr + k), words[k]});
            end else begin
                for (int k = 0; k <= full; k++) exp_rd_q.push_back(AW'(addr + k));
                for (int k = 0; k < full; k++) exp_rx_q.push_back(bank_word(addr + k));
            end
        end
        if (reset_bit < 0) done_pending++;

        rx = '0;
        rx_cnt = 0;
        cs_b = 1'b0;
        for (int i = 0; i < bits.size(); i++) begin
            if (i == reset_bit) begin
                reset = 1'b1;
                repeat (2) @(negedge axi_clk);
                reset = 1'b0;
                checkOutput("busy after reset", 64'(busy), 64'd0);
                checkOutput("wr_addr after reset", 64'(wr_addr), 64'd0);
                checkOutput("wr_data after reset", 64'(wr_data), 64'd0);
                checkOutput("poci after reset", 64'(poci), 64'd0);
            end
            pico = bits[i];
            repeat (half) @(negedge axi_clk);
            if (i == 0) checkOutput("busy in frame", 64'(busy), 64'd1);
            if (!wnr && i >= AW + 1 && reset_bit < 0) begin
                rx = {rx[DW-2:0], poci};
                rx_cnt++;
                if (rx_cnt == DW) begin
                    if (exp_rx_q.size() == 0) checkOutput("poci word spurious", 64'(rx), 64'hx);
                    else checkOutput("poci word", 64'(rx), 64'(exp_rx_q.pop_front()));
                    rx_cnt = 0;
                end
            end
            spi_clk = 1'b1;
            repeat (half) @(negedge axi_clk);
            spi_clk = 1'b0;
        end
        repeat (half) @(negedge axi_clk);
        cs_b = 1'b1;
        repeat (12) @(negedge axi_clk);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (4) @(negedge axi_clk);
        checkOutput("reset poci", 64'(poci), 64'd0);
        checkOutput("reset wr_en", 64'(wr_en), 64'd0);
        checkOutput("reset wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("reset wr_data", 64'(wr_data), 64'd0);
        checkOutput("reset rd_en", 64'(rd_en), 64'd0);
        checkOutput("reset rd_addr", 64'(rd_addr), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset frame_done", 64'(frame_done), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge axi_clk);

        w = '{32'hDEADBEEF, 32'h0, 32'h0};
        applyStimulus(1'b1, 'h005, 1, w, 4, -1, -1);
        w = '{32'h1, 32'h2, 32'h3};
        applyStimulus(1'b1, 'h3FF, 3, w, 32, -1, -1);
        applyStimulus(1'b0, 'h010, 2, w, 4, -1, -1);
        applyStimulus(1'b0, 'h010, 2, w, 32, -1, -1);
        w = '{32'h13579BDF, 32'h0, 32'h0};
        applyStimulus(1'b1, 'h123, 1, w, 4, AW + 1 + 17, -1);
        w = '{32'h0F0F1234, 32'h0, 32'h0};
        applyStimulus(1'b1, 'h200, 1, w, 4, -1, -1);
        w = '{32'hCAFEF00D, 32'h55AA33CC, 32'h0};
        applyStimulus(1'b1, 'h040, 2, w, 4, -1, AW + 1 + DW + 10);
        w = '{32'hA5A5A5A5, 32'h0, 32'h0};
        applyStimulus(1'b1, 'h001, 1, w, 4, -1, -1);
        applyStimulus(1'b1, 'h0AA, 0, w, 4, -1, -1);
        applyStimulus(1'b0, 'h3FF, 0, w, 4, -1, -1);
        applyStimulus(1'b0, 'h3FE, 3, w, 4, -1, -1);
        applyStimulus(1'b1, 'h100, 1, w, 4, 6, -1);

        for (int n = 0; n < 25; n++) begin
            bit rw;
            int a, nw, hp, ct;
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1020, 1023)) : int'($urandom_range(0, 1023));
            nw = $urandom_range(0, 2);
            hp = $urandom_range(4, 8);
            ct = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, AW + DW * nw)) : -1;
            for (int k = 0; k < 3; k++) w[k] = $urandom;
            applyStimulus(rw, a, nw, w, hp, ct, -1);
        end

        repeat (20) @(negedge axi_clk);
        checkOutput("writes outstanding", 64'(exp_wr_q.size()), 64'd0);
        checkOutput("reads outstanding", 64'(exp_rd_q.size()), 64'd0);
        checkOutput("read words outstanding", 64'(exp_rx_q.size()), 64'd0);
        checkOutput("frame_done outstanding", 64'(done_pending), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
